frame_streamer: RTL and testbench
=================================

// Module: frame_streamer
// PURPOSE
//  Sits directly downstream of the 16-word frame register file.
//  On start, takes one snapshot of all 16 frame_k_out words and streams them out one
//  word per handshake over a valid/ready link to the display/transmit stage.
//  The snapshot keeps a stream coherent even if the register file rewrites columns mid-stream.
//  Frame inputs change on negedge clk; this block samples on posedge, so they are stable when sampled.
// PARAMETERS
//  DATA_W     32  width of one frame word
//  NUM_WORDS  16  words per frame, laid out as a 4x4 grid, index = row*4 + col
//  COL_MAJOR  0   0: emit indices 0,1,2,...,15; 1: emit column by column (0,4,8,12,1,5,...,15)
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  frame_in   in   NUM_WORDS*DATA_W  word k on bits [k*DATA_W +: DATA_W]
//  start      in   1                 request to snapshot and stream one frame
//  out_data   out  DATA_W            current streamed word
//  out_index  out  5                 index of out_data: 0..15, or 16 for the checksum word
//  out_valid  out  1                 out_data/out_index/out_last are valid
//  out_ready  in   1                 consumer accepts when out_valid & out_ready
//  out_last   out  1                 marks the final word of the frame
//  busy       out  1                 high from the cycle after an accepted start through DONE
//  done       out  1                 one-cycle pulse after the final handshake
// BEHAVIOUR
//  - Reset, asynchronous, while rst_n=0:
//    - all outputs are 0 and the FSM is in IDLE
//    - the snapshot and the word counter are cleared to 0
//  - FSM states are IDLE, SEND, (CHK), DONE.
//  - IDLE: start=1 loads all 16 words into the snapshot on that edge, clears the counter, goes to SEND.
//  - Latency: start sampled at edge N, so out_valid=1 with the first word after edge N.
//  - SEND: out_valid=1, out_data = snapshot[order(cnt)], out_index = order(cnt).
//    - A handshake advances cnt on that edge.
//    - Without a handshake, out_data, out_index and out_last hold stable.
//    - Back-to-back handshakes give one word per cycle; 16 words take 16 cycles with out_ready held at 1.
//  - order(cnt) = cnt when COL_MAJOR=0; otherwise (cnt%4)*4 + cnt/4.
//  - Handshake on cnt=15 goes to CHK when FRAME_STREAM_CHK_EN is defined, else to DONE.
//  - DONE: out_valid=0, done=1 for exactly one cycle, then IDLE; busy drops on the return to IDLE.
//  - start is ignored unless the FSM is in IDLE; frame_in changes during a stream do not alter the stream.
//  - start is accepted in the cycle the FSM is back in IDLE after DONE; minimum frame-to-frame gap is 2 cycles.
//  - out_ready=1 while out_valid=0 has no effect.
//  - rst_n asserted mid-stream aborts immediately: no done pulse and no partial resume.
//  - The counter saturates in its state; it never wraps past the last index.
// CONFIGURATION
//  FRAME_STREAM_CHK_EN defined:
//    - an extra CHK state emits one word after word 15
//    - out_data = XOR of all 16 snapshot words, out_index = 16, out_last = 1
//    - out_last is 0 on word 15
//    - the CHK word follows the same hold rule; its handshake goes to DONE
//  FRAME_STREAM_CHK_EN undefined:
//    - no CHK state
//    - out_last = 1 on the word-15 beat (the last index emitted)
//    - out_index never reaches 16
// TESTING
//  1. Reset: hold rst_n=0, toggle start and out_ready -> every output stays 0; release -> IDLE with busy=0.
//  2. Row order: word k = 32'hA000_0000+k, COL_MAJOR=0, out_ready=1, start pulse ->
//     indices 0..15 on 16 consecutive cycles, data A0000000..A000000F, out_last on 15, done 1 cycle later.
//  3. Backpressure: toggle out_ready 1,0,0,1,... -> data held on every stall, no word skipped or repeated.
//  4. Coherency: change all frame_in words to 32'hFFFF_FFFF during word 3 ->
//     all 16 streamed words still carry the snapshot values; start pulses mid-stream are ignored.
//  5. COL_MAJOR=1 -> index order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
//  6. CHK_EN with words 1,2,4,...,32768 (word k = 1<<k) -> 17th word = 32'h0000_FFFF at index 16 with out_last.
//     Also assert rst_n at word 7 -> outputs clear at once, no done pulse.

Source files
------------

// File: rtl/frame_streamer.sv
// Snapshots a 4x4 frame of words on start and streams them over a valid/ready link.
// Optional `FRAME_STREAM_CHK_EN` appends an XOR checksum word (index 16) after the last data word.
module frame_streamer #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WORDS*DATA_W-1:0] frame_in,
  input  logic                        start,
  output logic [DATA_W-1:0]           out_data,
  output logic [4:0]                  out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

`ifdef FRAME_STREAM_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(NUM_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] CHK  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] snap [NUM_WORDS];
  logic [CNT_W-1:0]  order_idx;
  logic [DATA_W-1:0] checksum;
  logic              fire;
  logic              cnt_max;

  // On the 4x4 grid, column-major order just swaps the row and column halves of cnt.
  assign order_idx = COL_MAJOR ? {cnt[1:0], cnt[3:2]} : cnt;
  assign cnt_max   = (cnt == CNT_W'(NUM_WORDS - 1));
  assign fire      = out_valid && out_ready;

  always_comb begin
    checksum = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      checksum = checksum ^ snap[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      // NOTE: the snapshot is reset on purpose; out_data must read 0 and no stale frame may survive reset.
      for (int i = 0; i < NUM_WORDS; i++) begin
        snap[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              snap[i] <= frame_in[i*DATA_W +: DATA_W];
            end
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (cnt_max) begin
              state <= CHK_EN ? CHK : DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHK: begin
          if (fire) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no branch can infer a latch.
  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        out_data  = snap[order_idx];
        out_index = 5'(order_idx);
        out_last  = cnt_max && !CHK_EN;
      end
      CHK: begin
        out_valid = 1'b1;
        out_data  = checksum;
        out_index = 5'(NUM_WORDS);
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench: a row-major and a column-major instance share stimulus and are
// checked beat by beat against a queue of expected words built from the frame contents.
module tb_frame_streamer;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 16;
  localparam int FW        = DATA_W * NUM_WORDS;

`ifdef FRAME_STREAM_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx_row;
    logic [31:0] data_row;
    logic [4:0]  idx_col;
    logic [31:0] data_col;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [FW-1:0] frame_in = '0;

  logic [31:0] out_data  [2];
  logic [4:0]  out_index [2];
  logic        out_valid [2];
  logic        out_last  [2];
  logic        busy      [2];
  logic        done      [2];

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  frame_streamer #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .COL_MAJOR(1'b0)) dut_row (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .start(start),
    .out_data(out_data[0]), .out_index(out_index[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
  );

  frame_streamer #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .COL_MAJOR(1'b1)) dut_col (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .start(start),
    .out_data(out_data[1]), .out_index(out_index[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input int d, input logic v, input logic [4:0] idx,
                           input logic [31:0] data, input logic last,
                           input logic b, input logic dn);
    string n;
    n = (d == 0) ? "row" : "col";
    check({n, " valid"}, 32'(out_valid[d]), 32'(v));
    check({n, " index"}, 32'(out_index[d]), 32'(idx));
    check({n, " data"},  out_data[d], data);
    check({n, " last"},  32'(out_last[d]), 32'(last));
    check({n, " busy"},  32'(busy[d]), 32'(b));
    check({n, " done"},  32'(done[d]), 32'(dn));
  endtask

  // Expected stream straight from the frame: row order k, column order (k%4)*4 + k/4,
  // optionally followed by the XOR of all words at index 16.
  function automatic void build(input logic [FW-1:0] f);
    beat_t       b;
    logic [31:0] x;
    int          rc;
    exp_q.delete();
    x = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      rc         = (k % 4) * 4 + k / 4;
      b.idx_row  = 5'(k);
      b.data_row = f[k*DATA_W +: DATA_W];
      b.idx_col  = 5'(rc);
      b.data_col = f[rc*DATA_W +: DATA_W];
      b.last     = (k == NUM_WORDS - 1) && !CHK_EN;
      x          = x ^ f[k*DATA_W +: DATA_W];
      exp_q.push_back(b);
    end
    if (CHK_EN) begin
      b.idx_row  = 5'd16;
      b.idx_col  = 5'd16;
      b.data_row = x;
      b.data_col = x;
      b.last     = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // Entered and left on a negedge with the DUT idle. mode: 0 ready held, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input logic [FW-1:0] f, input int mode,
                           input int corrupt_at, input int reset_at);
    int    pops = 0;
    int    cyc = 0;
    int    nbeats;
    beat_t h;
    logic  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    build(f);
    nbeats   = exp_q.size();
    frame_in = f;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      h = exp_q[0];
      check_out(0, 1'b1, h.idx_row, h.data_row, h.last, 1'b1, 1'b0);
      check_out(1, 1'b1, h.idx_col, h.data_col, h.last, 1'b1, 1'b0);
      if (pops == reset_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (pops == corrupt_at) frame_in = '1;
      start = 1'($urandom_range(0, 1));
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      if (out_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream timeout", 32'(cyc < 200), 32'd1);
    if (mode == 0) check("stream cycles", 32'(cyc), 32'(nbeats));
    start     = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [FW-1:0] f;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start     = i[0];
      out_ready = ~i[0];
      frame_in  = {NUM_WORDS{$urandom}};
      #1;
      for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_out(d, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NUM_WORDS; k++) f[k*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(k);
    run_frame(f, 0, -1, -1);
    run_frame(f, 1, -1, -1);
    run_frame(f, 2, 3, -1);

    for (int k = 0; k < NUM_WORDS; k++) f[k*DATA_W +: DATA_W] = 32'd1 << k;
    run_frame(f, 0, -1, -1);
    run_frame(f, 0, -1, 7);
    run_frame(f, 1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NUM_WORDS; k++) f[k*DATA_W +: DATA_W] = $urandom;
      run_frame(f, (r == 0) ? 0 : 2, r * 4, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
